fifo_out_ctrl: RTL and testbench
================================

Name: fifo_out_ctrl

Overview:
Credit-based issue controller for the output FIFO (fifo_out) that sits behind a fixed-latency compute pipeline (MAC datapath).
- Decides each cycle whether the pipeline may launch one more result (issue_en), so every launched result is guaranteed a free FIFO slot when it emerges LAT cycles later.
- Generates the FIFO's wr_en, counts results per job and reports busy/done to the top-level sequencer.

Parameters:
DEPTH, 17, depth of the downstream output FIFO; sets capacity width $clog2(DEPTH+1)
LAT, 4, cycles from an issue_en cycle to the matching fifo_wr_en cycle; legal range 1..64
CNTW, 16, width of the job length and result counters

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  begin job; sampled only in IDLE
num_out  in  CNTW  results in this job; latched on accepted start
capacity  in  $clog2(DEPTH+1)  free slots reported by the FIFO (registered there)
issue_en  out  1  pipeline may launch one result this cycle
fifo_wr_en  out  1  write strobe to the FIFO, aligned with the pipeline result
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse in DONE
stall_cycles  out  32  present only with FIFO_OUT_CTRL_STALL_CNT_EN

Behaviour:
- State machine: IDLE, RUN, DRAIN, DONE.
- Reset values: state=IDLE; issued=0; inflight=0; LAT-bit delay line all zero. All outputs 0 (stall_cycles=0).
- IDLE:
  - start=1 latches num_out into len.
  - len!=0 goes to RUN; num_out==0 goes straight to DONE.
  - start is ignored in every other state.
- RUN:
  - issue_en = (capacity > inflight) && (issued < len). Compare is unsigned; inflight is zero-extended.
  - When issue_en=1, issued increments.
  - The issue that brings issued to len moves the FSM to DRAIN on the same edge.
- DRAIN: issue_en=0. Go to DONE on the edge where inflight==0 and the delay line is all zero.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. issued clears on leaving DONE.
- Delay line: an LAT-stage shift register that shifts in issue_en every cycle. fifo_wr_en = last stage, so issue at cycle t gives fifo_wr_en at cycle t+LAT.
- inflight counter, width $clog2(LAT+2):
  - +1 on an edge with issue_en=1.
  - -1 on an edge with fifo_wr_en=1.
  - Unchanged when both happen on the same edge.
  - Never exceeds LAT+1.
- Credit rationale: the FIFO lowers capacity on the same edge as fifo_wr_en, and inflight drops on that edge too. capacity - inflight is therefore never overstated, and FIFO reads only raise capacity.
- Required invariant: the FIFO never receives wr_en while capacity==0.
- Full FIFO (capacity==0, or capacity<=inflight): issue_en=0 with no loss. Issue resumes the cycle after capacity rises above inflight.
- Back-to-back issue at 1 result/cycle is sustained whenever capacity > inflight+1.
- Reset mid-job: the delay line is cleared, so no fifo_wr_en is emitted after reset for results issued before it. The FSM returns to IDLE.

Optional Feature:
Macro FIFO_OUT_CTRL_STALL_CNT_EN.
- Defined: adds a 32-bit stall_cycles output. It counts cycles in RUN with issued<len and issue_en=0 (credit stall), saturates at 2^32-1, and clears on reset and on each accepted start.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Basic job, LAT=4, DEPTH=17, capacity held 17, start with num_out=5 -> issue_en high 5 consecutive cycles, fifo_wr_en high 5 cycles starting 4 cycles later, done pulses once, busy low after.
- Full FIFO: capacity=0 at start, num_out=3 -> issue_en stays 0. Raise capacity to 2 -> exactly 2 issues, 3rd withheld until capacity > inflight, no wr_en ever seen with capacity==0.
- Credit race, FIFO model with reader stalled, DEPTH=17, num_out=40 -> exactly 17 writes accepted then issue_en=0. Release the reader at 1 word/cycle -> all 40 delivered, done pulse, inflight returns to 0.
- Zero-length and ignored start: num_out=0 -> done one cycle after start, no issue_en. A second start asserted during RUN -> ignored, job length unchanged.
- Reset mid-job: reset asserted 2 cycles after 3 issues with LAT=4 -> no fifo_wr_en after reset, outputs at reset values, a new job runs correctly.
- Macro defined: capacity held at 1 with the FIFO model never reading, num_out=3 -> stall_cycles increments every RUN cycle after the first issue. A new start clears it to 0.

Source files
------------

// File: rtl/fifo_out_ctrl.sv
// Credit-based issue controller for the output FIFO behind a fixed-latency pipeline.
// A result is launched only when the FIFO has a free slot for it that no earlier
// launch has already claimed, so the FIFO can never overflow.
// Optional macro FIFO_OUT_CTRL_STALL_CNT_EN adds the stall_cycles credit-stall counter.
module fifo_out_ctrl #(
    parameter int unsigned DEPTH = 17,
    parameter int unsigned LAT   = 4,
    parameter int unsigned CNTW  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CNTW-1:0]            num_out,
    input  logic [$clog2(DEPTH+1)-1:0] capacity,
    output logic                       issue_en,
    output logic                       fifo_wr_en,
    output logic                       busy,
    output logic                       done
`ifdef FIFO_OUT_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int unsigned CAPW = $clog2(DEPTH + 1);
    localparam int unsigned INFW = $clog2(LAT + 2);
    localparam int unsigned CMPW = (CAPW > INFW) ? CAPW : INFW;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] len_q, len_d;
    logic [CNTW-1:0] issued_q, issued_d;
    logic [INFW-1:0] inflight_q, inflight_d;
    logic [LAT-1:0]  delay_q, delay_d;

    logic            start_accept;
    logic            issue_pending;
    logic            credit_ok;
    logic [CMPW-1:0] cap_ext;
    logic [CMPW-1:0] inflight_ext;

    assign start_accept  = (state_q == StIdle) && start;
    assign issue_pending = (issued_q < len_q);
    assign cap_ext       = CMPW'(capacity);
    assign inflight_ext  = CMPW'(inflight_q);
    // Free slots minus results already on their way must leave room for one more.
    assign credit_ok     = (cap_ext > inflight_ext);

    // Combinational outputs decoded from the current state and delay line.
    always_comb begin
        issue_en   = (state_q == StRun) && credit_ok && issue_pending;
        fifo_wr_en = delay_q[LAT-1];
        busy       = (state_q == StRun) || (state_q == StDrain);
        done       = (state_q == StDone);
    end

    // Delay line mirrors the pipeline: each issue re-emerges as a write LAT cycles later.
    if (LAT == 1) begin : g_delay_one
        assign delay_d = issue_en;
    end else begin : g_delay_many
        assign delay_d = {delay_q[LAT-2:0], issue_en};
    end

    // Next-state logic for the FSM, job length and result counter.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = num_out;
                    state_d = (num_out == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (issue_en) begin
                    issued_d = issued_q + CNTW'(1);
                    if (issued_d == len_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if ((inflight_q == '0) && (delay_q == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                issued_d = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // In-flight count: an issue and a write on the same edge cancel out.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue_en, fifo_wr_en})
            2'b10:   inflight_d = inflight_q + INFW'(1);
            2'b01:   inflight_d = inflight_q - INFW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; reset also flushes the delay line so no stale writes escape.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= '0;
            delay_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            delay_q    <= delay_d;
        end
    end

`ifdef FIFO_OUT_CTRL_STALL_CNT_EN
    logic stall_now;
    assign stall_now = (state_q == StRun) && issue_pending && !issue_en;

    // Saturating count of RUN cycles lost to missing credit; restarts with each job.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            stall_cycles <= '0;
        end else if (stall_now && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_fifo_out_ctrl.sv
// Testbench for fifo_out_ctrl: cycle vectors for the basic, zero-length, ignored-start and
// full-FIFO jobs, then sequences for the credit race, mid-job reset and stall counter.
module tb_fifo_out_ctrl;

    localparam int unsigned DEPTH = 17;
    localparam int unsigned LAT   = 4;
    localparam int unsigned CNTW  = 16;
    localparam int unsigned CAPW  = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [CNTW-1:0] num_out;
    logic [CAPW-1:0] capacity;
    logic            issue_en;
    logic            fifo_wr_en;
    logic            busy;
    logic            done;
`ifdef FIFO_OUT_CTRL_STALL_CNT_EN
    logic [31:0]     stall_cycles;
`endif

    always #5 clk = ~clk;

    fifo_out_ctrl #(
        .DEPTH (DEPTH),
        .LAT   (LAT),
        .CNTW  (CNTW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_out    (num_out),
        .capacity   (capacity),
        .issue_en   (issue_en),
        .fifo_wr_en (fifo_wr_en),
        .busy       (busy),
        .done       (done)
`ifdef FIFO_OUT_CTRL_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    typedef struct {
        logic        start;
        logic [15:0] num_out;
        logic [4:0]  capacity;
        logic        issue;
        logic        wr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int passes = 0;

    // FIFO model and per-cycle samples
    int          occ = 0;
    logic        model_on = 1'b0;
    logic        reader_en = 1'b0;
    logic        s_issue, s_wr, s_busy, s_done;
    logic [31:0] s_stall = 32'd0;
    int          wr_cnt = 0, issue_cnt = 0, done_cnt = 0, viol = 0;

    task automatic check(input string name, input int idx, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    endtask

    function automatic void add(input logic s, input int n, input int c,
                                input logic i, input logic w, input logic b, input logic d);
        vec_t v;
        v.start    = s;
        v.num_out  = 16'(n);
        v.capacity = 5'(c);
        v.issue    = i;
        v.wr       = w;
        v.busy     = b;
        v.done     = d;
        vecs.push_back(v);
    endfunction

    // One clock cycle: sample outputs at negedge, then advance the FIFO model after the edge.
    task automatic step();
        logic w, rd;
        @(negedge clk);
        s_issue = issue_en;
        s_wr    = fifo_wr_en;
        s_busy  = busy;
        s_done  = done;
`ifdef FIFO_OUT_CTRL_STALL_CNT_EN
        s_stall = stall_cycles;
`endif
        if (fifo_wr_en && (capacity == '0)) begin
            viol++;
            $display("FAIL wr_at_zero_capacity[%0d]: got wr_en=1, expected 0", viol);
        end
        w  = fifo_wr_en;
        rd = reader_en && (occ > 0);
        wr_cnt    += int'(fifo_wr_en);
        issue_cnt += int'(issue_en);
        done_cnt  += int'(done);
        @(posedge clk);
        #1;
        if (model_on) begin
            occ      = occ + int'(w) - int'(rd);
            capacity = CAPW'(DEPTH - occ);
        end
    endtask

    task automatic clear_counts();
        wr_cnt = 0;
        issue_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic run_to_done(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog[0]: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        num_out  = '0;
        capacity = CAPW'(DEPTH);
        @(posedge clk);
        #1;
        step();
        check("reset_issue", 0, s_issue, 0);
        check("reset_wr", 0, s_wr, 0);
        check("reset_busy", 0, s_busy, 0);
        check("reset_done", 0, s_done, 0);
        reset = 1'b0;

        // Basic job, len 5, full credit
        add(1, 5, 17, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 17, 1, 0, 1, 0);
        add(0, 0, 17, 1, 1, 1, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 17, 0, 1, 1, 0);
        add(0, 0, 17, 0, 0, 1, 0);
        add(0, 0, 17, 0, 0, 0, 1);
        // Zero-length job
        add(1, 0, 17, 0, 0, 0, 0);
        add(0, 0, 17, 0, 0, 0, 1);
        add(0, 0, 17, 0, 0, 0, 0);
        // Start during RUN is ignored: only 2 issues
        add(1, 2, 17, 0, 0, 0, 0);
        add(1, 9, 17, 1, 0, 1, 0);
        add(0, 0, 17, 1, 0, 1, 0);
        add(0, 0, 17, 0, 0, 1, 0);
        add(0, 0, 17, 0, 0, 1, 0);
        add(0, 0, 17, 0, 1, 1, 0);
        add(0, 0, 17, 0, 1, 1, 0);
        add(0, 0, 17, 0, 0, 1, 0);
        add(0, 0, 17, 0, 0, 0, 1);
        add(0, 0, 17, 0, 0, 0, 0);
        // Full FIFO, then capacity 2: third issue waits for inflight to drop
        add(1, 3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 2, 1, 0, 1, 0);
        add(0, 0, 2, 1, 0, 1, 0);
        add(0, 0, 2, 0, 0, 1, 0);
        add(0, 0, 2, 0, 0, 1, 0);
        add(0, 0, 2, 0, 1, 1, 0);
        add(0, 0, 2, 1, 1, 1, 0);
        add(0, 0, 2, 0, 0, 1, 0);
        add(0, 0, 2, 0, 0, 1, 0);
        add(0, 0, 2, 0, 0, 1, 0);
        add(0, 0, 2, 0, 1, 1, 0);
        add(0, 0, 2, 0, 0, 1, 0);
        add(0, 0, 2, 0, 0, 0, 1);
        add(0, 0, 2, 0, 0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            start    = vecs[k].start;
            num_out  = vecs[k].num_out;
            capacity = vecs[k].capacity;
            @(negedge clk);
            check("vec_issue", k, issue_en, vecs[k].issue);
            check("vec_wr", k, fifo_wr_en, vecs[k].wr);
            check("vec_busy", k, busy, vecs[k].busy);
            check("vec_done", k, done, vecs[k].done);
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        // Credit race: reader stalled, 40 results into a 17-deep FIFO
        model_on  = 1'b1;
        occ       = 0;
        capacity  = CAPW'(DEPTH);
        reader_en = 1'b0;
        viol      = 0;
        clear_counts();
        start   = 1'b1;
        num_out = 16'd40;
        step();
        start = 1'b0;
        repeat (40) step();
        check("race_writes_held", 0, wr_cnt, 17);
        check("race_issues_held", 0, issue_cnt, 17);
        check("race_issue_off", 0, s_issue, 0);
        check("race_busy_held", 0, s_busy, 1);
        reader_en = 1'b1;
        run_to_done(400);
        check("race_done_seen", 0, done_cnt, 1);
        check("race_writes_all", 0, wr_cnt, 40);
        check("race_issues_all", 0, issue_cnt, 40);
        repeat (5) step();
        check("race_done_once", 0, done_cnt, 1);
        check("race_no_extra_wr", 0, wr_cnt, 40);
        check("race_busy_after", 0, s_busy, 0);
        check("race_no_overflow", 0, viol, 0);

        // Reset mid-job: 3 issues, reset 2 cycles later, no stale writes afterwards
        model_on = 1'b0;
        capacity = CAPW'(DEPTH);
        clear_counts();
        start   = 1'b1;
        num_out = 16'd3;
        step();
        start = 1'b0;
        repeat (3) step();
        check("rst_pre_issues", 0, issue_cnt, 3);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_counts();
        step();
        check("rst_issue", 1, s_issue, 0);
        check("rst_wr", 1, s_wr, 0);
        check("rst_busy", 1, s_busy, 0);
        check("rst_done", 1, s_done, 0);
`ifdef FIFO_OUT_CTRL_STALL_CNT_EN
        check("rst_stall", 1, s_stall, 0);
`endif
        repeat (8) step();
        check("rst_no_stale_wr", 0, wr_cnt, 0);
        check("rst_no_issue", 0, issue_cnt, 0);
        clear_counts();
        start   = 1'b1;
        num_out = 16'd2;
        step();
        start = 1'b0;
        run_to_done(40);
        check("rst_job_done", 0, done_cnt, 1);
        check("rst_job_issues", 0, issue_cnt, 2);
        check("rst_job_writes", 0, wr_cnt, 2);

`ifdef FIFO_OUT_CTRL_STALL_CNT_EN
        // Capacity 1, reader never reads: every RUN cycle after the first issue is a stall
        model_on  = 1'b1;
        occ       = 16;
        capacity  = CAPW'(DEPTH - occ);
        reader_en = 1'b0;
        clear_counts();
        start   = 1'b1;
        num_out = 16'd3;
        step();
        start = 1'b0;
        step();
        check("stall_first_issue", 0, s_issue, 1);
        check("stall_cleared", 0, s_stall, 0);
        repeat (11) step();
        check("stall_count", 0, s_stall, 10);
        reader_en = 1'b1;
        run_to_done(200);
        check("stall_job_done", 0, done_cnt, 1);
        clear_counts();
        start   = 1'b1;
        num_out = 16'd1;
        step();
        start = 1'b0;
        step();
        check("stall_new_issue", 0, s_issue, 1);
        check("stall_new_cleared", 0, s_stall, 0);
        run_to_done(40);
        check("stall_new_done", 0, done_cnt, 1);
        check("stall_no_overflow", 0, viol, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
